// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the dual-clock FIFO and re-presents words as a valid/ready stream.
// Optional pop counter on rd_count is enabled by defining FIFO_RD_CNT_EN.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 empty,
    input  logic [WIDTH-1:0]     rdata,
    output logic                 read_en,
    input  logic                 flush,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count
`endif
);

    // Handshake: a word transfers on any rclk edge where m_valid & m_ready;
    // m_valid never drops and m_data never changes until that transfer.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               inflight_q, inflight_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic               pop;
    logic               pop_acc;
    logic               capture;
    logic               read_en_int;
    logic [2:0]         level;
    logic [2:0]         limit;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pop         = (state_q != S_EMPTY) & m_ready;
        pop_acc     = pop & !flush;
        capture     = inflight_q & !flush;
        level       = {1'b0, state_q} + {2'b00, inflight_q};
        limit       = 3'd2 + {2'b00, pop};
        // Words already owned (buffered + in flight) minus the one leaving must leave a free slot.
        read_en_int = !empty & !flush & (level < limit);
        inflight_d  = read_en_int;

        case (state_q)
            S_EMPTY: begin
                if (capture) begin
                    head_d  = rdata;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                case ({capture, pop_acc})
                    2'b10: begin
                        tail_d  = rdata;
                        state_d = S_TWO;
                    end
                    2'b01:   state_d = S_EMPTY;
                    2'b11:   head_d  = rdata;
                    default: state_d = S_ONE;
                endcase
            end
            S_TWO: begin
                // Capture without pop cannot happen here: read_en is held off at two owned words.
                if (pop_acc) begin
                    head_d = tail_q;
                    if (capture) begin
                        tail_d = rdata;
                    end else begin
                        state_d = S_ONE;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q    <= S_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign read_en = read_en_int & !rrst;
    assign m_valid = (state_q != S_EMPTY);
    assign m_data  = head_q;

`ifdef FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop_acc};
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_count = cnt_q;
`else
    // Keeps CNT_WIDTH referenced when the counter is compiled out.
    logic [CNT_WIDTH-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
    logic unused_pop_acc;
    assign unused_pop_acc = pop_acc;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO environment model, queue-based reference model, directed + random stimulus.
module tb_fifo_rd_stream;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         rclk = 1'b0;
  logic         rrst;
  logic         empty;
  logic [W-1:0] rdata;
  logic         read_en;
  logic         flush;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
`ifdef FIFO_RD_CNT_EN
  logic [CW-1:0] rd_count;
`endif

  fifo_rd_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .empty   (empty),
    .rdata   (rdata),
    .read_en (read_en),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  // clock / reset
  always #5 rclk = ~rclk;

  // FIFO environment
  logic [W-1:0] fifo_q[$];
  bit           pend_pop;
  logic [W-1:0] pend_word;

  // reference model: buffered words, word in flight, delivered count
  logic [W-1:0] exp_q[$];
  bit           m_inflight;
  logic [W-1:0] m_inflight_word;
  int           m_count;

  logic [W-1:0] del_q[$];
  int           cyc;
  int           first_re_cyc;
  int           first_v_cyc;
  int           n_checks;
  int           n_fail;
  bit           e_valid;
  bit           e_pop;
  bit           e_re;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // compare process: outputs are settled at the falling edge
  always @(negedge rclk) begin
    cyc++;
    if (rrst) begin
      check("rst_read_en", {31'd0, read_en}, 32'd0);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_data", {24'd0, m_data}, 32'd0);
`ifdef FIFO_RD_CNT_EN
      check("rst_rd_count", {28'd0, rd_count}, 32'd0);
`endif
      exp_q.delete();
      m_inflight = 1'b0;
      m_count    = 0;
      pend_pop   = 1'b0;
    end else begin
      e_valid = (exp_q.size() != 0);
      e_pop   = e_valid && m_ready;
      e_re    = !empty && !flush && (int'(exp_q.size()) + int'(m_inflight) < 2 + int'(e_pop));
      check("read_en", {31'd0, read_en}, {31'd0, e_re});
      check("m_valid", {31'd0, m_valid}, {31'd0, e_valid});
      if (e_valid) check("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
`ifdef FIFO_RD_CNT_EN
      check("rd_count", {28'd0, rd_count}, m_count % 16);
`endif
      check("read_en_while_empty", {31'd0, read_en && empty}, 32'd0);
      if (read_en && first_re_cyc < 0) first_re_cyc = cyc;
      if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (m_valid && m_ready && !flush) del_q.push_back(m_data);
      pend_pop = read_en && !empty && (fifo_q.size() != 0);
      if (pend_pop) pend_word = fifo_q[0];
      if (flush) begin
        exp_q.delete();
        m_inflight = 1'b0;
      end else begin
        if (e_pop) begin
          void'(exp_q.pop_front());
          m_count++;
        end
        if (m_inflight) exp_q.push_back(m_inflight_word);
        check("occupancy_le_2", {31'd0, exp_q.size() <= 2}, 32'd1);
        m_inflight = e_re;
        if (e_re && fifo_q.size() != 0) m_inflight_word = fifo_q[0];
      end
    end
  end

  // driver: advance one cycle, apply FIFO response, then this cycle's inputs
  task automatic step(input bit rdy, input bit fl, input bit do_push, input logic [W-1:0] w);
    @(posedge rclk);
    #1;
    if (pend_pop) begin
      void'(fifo_q.pop_front());
      rdata    = pend_word;
      pend_pop = 1'b0;
    end else begin
      rdata = W'($urandom);
    end
    if (do_push) fifo_q.push_back(w);
    empty   = (fifo_q.size() == 0);
    m_ready = rdy;
    flush   = fl;
  endtask

  task automatic drain(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (int'(del_q.size()) < n && b > 0) begin
      step(1'b1, 1'b0, 1'b0, '0);
      b--;
    end
    check(name, del_q.size(), n);
  endtask

  initial begin
    bit rdy;
    bit fl;
    cyc = 0; n_checks = 0; n_fail = 0; m_count = 0;
    first_re_cyc = -1; first_v_cyc = -1;
    rrst = 1'b1; empty = 1'b1; flush = 1'b0; m_ready = 1'b0; rdata = '0;
    pend_pop = 1'b0; m_inflight = 1'b0;

    // reset held with a non-empty FIFO, then streaming of 0x01..0x10
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b1, W'(i));
    step(1'b1, 1'b0, 1'b0, '0);
    check("rst_hold_read_en", {31'd0, read_en}, 32'd0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    #1;
    check("release_read_en", {31'd0, read_en}, 32'd1);
    del_q.delete();
    drain(16, 40, "stream_count");
    for (int i = 0; i < 16; i++) check("stream_word", {24'd0, del_q[i]}, i + 1);
    check("first_word_latency", first_v_cyc - first_re_cyc, 32'd2);
`ifdef FIFO_RD_CNT_EN
    check("stream_rd_count", {28'd0, rd_count}, 32'd0);
`endif

    // backpressure: 8 words, sink stalled for 10 cycles
    del_q.delete();
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    empty = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("bp_pops_issued", 8 - fifo_q.size(), 32'd2);
    check("bp_m_valid", {31'd0, m_valid}, 32'd1);
    check("bp_m_data", {24'd0, m_data}, 32'h01);
    drain(8, 40, "bp_count");
    for (int i = 0; i < 8; i++) check("bp_word", {24'd0, del_q[i]}, i + 1);

    // flush while one word is buffered and one is in flight
    del_q.delete();
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) fifo_q.push_back(W'(8'h21 + i));
    empty = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("flush_m_valid_next", {31'd0, m_valid}, 32'd0);
    drain(2, 20, "flush_count");
    check("flush_next_word", {24'd0, del_q[0]}, 32'h23);
    check("flush_after_word", {24'd0, del_q[1]}, 32'h24);

    // sparse arrivals: one word every 3 cycles
    del_q.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b1, W'(8'h40 + i));
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
    end
    drain(12, 20, "sparse_count");
    for (int i = 0; i < 12; i++) check("sparse_word", {24'd0, del_q[i]}, 32'h40 + i);

    // random traffic with occasional flushes, then a mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      fl  = ($urandom_range(0, 40) == 0);
      rdy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(rdy, fl, $urandom_range(0, 1) == 1, W'($urandom));
    end
    @(posedge rclk);
    #3;
    rrst = 1'b1;
    #1;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_read_en", {31'd0, read_en}, 32'd0);
    check("midrst_m_data", {24'd0, m_data}, 32'd0);
    fifo_q.delete();
    empty = 1'b1; flush = 1'b0; m_ready = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    rrst = 1'b0;

    // 17 pops from a fresh reset
    del_q.delete();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 17; i++) fifo_q.push_back(W'(8'h80 + i));
    empty = 1'b0;
    drain(17, 60, "wrap_count");
    check("wrap_last_word", {24'd0, del_q[16]}, 32'h90);
`ifdef FIFO_RD_CNT_EN
    check("wrap_rd_count", {28'd0, rd_count}, 32'd1);
`endif
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the dual-clock FIFO. Lives entirely in the read clock domain.
- Drives the FIFO read port (read_en/rdata/empty) and re-presents the popped words as a valid/ready stream to downstream logic.
- Hides the FIFO's one-cycle registered read latency with a 2-entry prefetch buffer, so a continuously-ready sink receives one word per rclk.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
CNT_WIDTH, 16, width of the pop counter; used only when FIFO_RD_CNT_EN is defined.

Ports:
rclk  input  1  read-domain clock; all logic on rising edge.
rrst  input  1  asynchronous, active-high reset.
empty  input  1  FIFO empty flag, already synchronous to rclk.
rdata  input  WIDTH  FIFO read data; valid in the cycle after a pop.
read_en  output  1  FIFO pop request; combinational from registered state, empty and m_ready.
flush  input  1  synchronous drop of all buffered and in-flight words.
m_data  output  WIDTH  stream data, equal to the buffer head.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready from sink.
rd_count  output  CNT_WIDTH  words delivered; present only with FIFO_RD_CNT_EN.

Behaviour:
Interface decision:
- One clock (rclk); reset rrst is asynchronous and active-high.

Reset:
- Asserting rrst immediately clears occ=0, inflight=0, m_valid=0 and m_data=0.
- read_en=0 while rrst is high.
- rd_count=0.

FIFO contract:
- read_en high with empty=0 at edge N pops one word.
- That word appears on rdata throughout cycle N+1.
- The block must never assert read_en while empty=1.

Internal state:
- occ ∈ {0,1,2}: buffered words, managed as FSM states EMPTY / ONE / TWO.
- inflight ∈ {0,1}: a pop was issued last cycle.
- pop = m_valid & m_ready.
- read_en = !empty & !flush & ((occ + inflight − pop) < 2).

Capture and pop:
- When inflight=1, rdata is written into the buffer at the end of that cycle.
- inflight next = read_en.
- The buffer is a 2-entry FIFO (head/tail registers or ptr-indexed). Capture goes to the tail; pop removes the head.

FSM transitions, per edge (capture = inflight & !flush):
- EMPTY: capture → ONE; else stay.
- ONE: capture & !pop → TWO; pop & !capture → EMPTY; capture & pop, or neither → ONE.
- TWO: pop & !capture → ONE; capture & pop → TWO. capture & !pop is impossible by construction; the bench asserts it never occurs.

Outputs:
- m_valid = (occ != 0).
- m_data = head entry; stable while m_valid & !m_ready.
- Standard valid/ready rules: once m_valid rises it stays high until pop.

Throughput and latency:
- Steady state with m_ready=1 and FIFO non-empty: occ=1, inflight=1, one word per cycle.
- First word: empty falls at cycle 0 → read_en in cycle 0 → m_valid high in cycle 2.

Flush:
- In the flush cycle: read_en=0, no capture, no pop accounted.
- At the edge: occ←0, inflight←0.
- A word popped the previous cycle is discarded.
- m_valid=0 from the next cycle. rd_count is unaffected.

Boundaries:
- empty rising while inflight=1: the in-flight word is still captured.
- m_ready low with occ=2: read_en stays 0 until a pop.
- rrst asserted mid-stream: buffered words are lost, with no partial outputs.

Optional Feature:
FIFO_RD_CNT_EN
- Defined: rd_count port exists; increments by 1 on every pop and wraps modulo 2^CNT_WIDTH. Reset by rrst only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rrst high with empty=0 → read_en=0, m_valid=0, m_data=0. Release rrst → read_en=1 in the next cycle.
2. Streaming: preload FIFO model with 0x01..0x10, m_ready=1 → m_data sequence 0x01..0x10 on 16 consecutive cycles; first m_valid 2 cycles after the first read_en; rd_count=16.
3. Backpressure: 8 words, m_ready=0 for 10 cycles → exactly 2 pops issued, occ=2, m_data=0x01 held stable. Raise m_ready → remaining words 0x01..0x08 in order, no loss or duplication.
4. Flush with inflight: flush one cycle after a pop is issued while occ=1 → m_valid=0 next cycle. The in-flight word is dropped. The next delivered word is the following FIFO entry.
5. Empty toggling: FIFO receives 1 word every 3 cycles, m_ready=1 → each word delivered exactly once; read_en is never high while empty=1 (assertion).
6. Counter wrap (macro on, CNT_WIDTH=4): 17 pops → rd_count=1.
